if_id_queue: RTL and testbench

Instruction buffer between the fetch stage and the decode stage. It captures each fetched instruction word together with its PC and PC+4, and holds up to DEPTH entries in a show-ahead FIFO. Entries are handed to decode under a valid/ready handshake. Fetch stalls are decoupled from decode stalls, and a single-cycle flush discards all buffered instructions when a branch is redirected.

---
 rtl/if_id_queue_if.sv | 31 +++
 rtl/if_id_queue.sv | 91 +++++++++
 tb/tb_if_id_queue.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// Fetch->decode handshake bundle: fetch write port, decode read port, flush and occupancy.
// Combinational only: the queue behind it fixes latency and backpressure behaviour.
// master = fetch/decode environment side, slave = queue side.
interface if_id_queue_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          f_valid;
    logic [31:0]   f_ins;
    logic [31:0]   f_pc;
    logic [31:0]   f_pc_plus_4;
    logic          f_ready;
    logic          d_valid;
    logic [31:0]   d_ins;
    logic [31:0]   d_pc;
    logic [31:0]   d_pc_plus_4;
    logic          d_ready;
    logic          flush;
    logic [CW-1:0] count;

    modport master (
        output f_valid, f_ins, f_pc, f_pc_plus_4, d_ready, flush,
        input  f_ready, d_valid, d_ins, d_pc, d_pc_plus_4, count
    );

    modport slave (
        input  f_valid, f_ins, f_pc, f_pc_plus_4, d_ready, flush,
        output f_ready, d_valid, d_ins, d_pc, d_pc_plus_4, count
    );
endinterface

// File: rtl/if_id_queue.sv
// Show-ahead fetch->decode instruction FIFO of {ins, pc, pc+4}; optional IFQ_BUBBLE_CNT_EN adds bubble_cnt.
// Latency: write to d_valid is 1 cycle (no empty bypass); 1 entry/cycle sustained when neither empty nor full.
// Backpressure: f_ready/d_valid come from registered count only; no write-through when full; flush wins over both.
module if_id_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    if_id_queue_if.slave q
`ifdef IFQ_BUBBLE_CNT_EN
    ,
    output logic [31:0] bubble_cnt
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0]   NOP  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] pc_plus_4;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          f_ready;
    logic          d_valid;
    logic          wr_en;
    logic          rd_en;

    assign f_ready = (count_q != FULL);
    assign d_valid = (count_q != '0);
    assign wr_en   = q.f_valid && f_ready && !q.flush;
    assign rd_en   = d_valid && q.d_ready && !q.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (q.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is deliberately left uncleared by reset and flush; d_valid gates its visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= '{ins: q.f_ins, pc: q.f_pc, pc_plus_4: q.f_pc_plus_4};
        end
    end

    always_comb begin
        head = '{ins: NOP, pc: '0, pc_plus_4: '0};
        if (d_valid) head = mem[rd_ptr];
    end

    assign q.f_ready     = f_ready;
    assign q.d_valid     = d_valid;
    assign q.d_ins       = head.ins;
    assign q.d_pc        = head.pc;
    assign q.d_pc_plus_4 = head.pc_plus_4;
    assign q.count       = count_q;

`ifdef IFQ_BUBBLE_CNT_EN
    // Decode starvation: decode asked but nothing was there; saturates, immune to flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (q.d_ready && !d_valid && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue (DEPTH=2): per-cycle vector table for handshake state plus a PC scoreboard for data order.
module tb_if_id_queue;
    localparam int DEPTH = 2;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    if_id_queue_if #(.DEPTH(DEPTH)) qif ();
`ifdef IFQ_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .q   (qif.slave)
`ifdef IFQ_BUBBLE_CNT_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        dr;
        logic        fl;
        int          exp_count;
        logic        exp_f_ready;
        logic        exp_d_valid;
        logic [31:0] exp_d_pc;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return 32'hA500_0000 ^ pc;
    endfunction

    function automatic vec_t mk(input logic fv, input logic [31:0] pc, input logic dr, input logic fl,
                                input int c, input logic fr, input logic dv, input logic [31:0] dpc);
        vec_t v;
        v.fv = fv; v.pc = pc; v.dr = dr; v.fl = fl;
        v.exp_count = c; v.exp_f_ready = fr; v.exp_d_valid = dv; v.exp_d_pc = dpc;
        return v;
    endfunction

    task automatic drive(input logic fv, input logic [31:0] pc, input logic dr, input logic fl);
        qif.f_valid     = fv;
        qif.f_pc        = pc;
        qif.f_ins       = ins_of(pc);
        qif.f_pc_plus_4 = pc + 32'd4;
        qif.d_ready     = dr;
        qif.flush       = fl;
    endtask

    task automatic check_empty_outputs(input string tag);
        check({tag, " d_ins NOP"}, qif.d_ins, NOP);
        check({tag, " d_pc zero"}, qif.d_pc, 32'h0);
        check({tag, " d_pc4 zero"}, qif.d_pc_plus_4, 32'h0);
    endtask

    initial begin
        logic [31:0] exp_pc;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset state
        #1;
        check("reset count", 32'(qif.count), 32'd0);
        check("reset f_ready", 32'(qif.f_ready), 32'd1);
        check("reset d_valid", 32'(qif.d_valid), 32'd0);
        check_empty_outputs("reset");
`ifdef IFQ_BUBBLE_CNT_EN
        check("reset bubble_cnt", bubble_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Fill to full, drop third write, then full read+write: only the read happens
        vecs.push_back(mk(1, 32'h0, 0, 0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 32'h4, 0, 0, 1, 1, 1, 32'h0));
        vecs.push_back(mk(1, 32'h8, 0, 0, 2, 0, 1, 32'h0));
        vecs.push_back(mk(1, 32'hC, 1, 0, 2, 0, 1, 32'h0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 1, 1, 1, 32'h4));
        // 10 cycles streaming; head lags the write by one entry
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(1, 32'h100 + 32'(4 * k), 1, 0, 1, 1, 1,
                              (k == 0) ? 32'h4 : 32'h100 + 32'(4 * (k - 1))));
        vecs.push_back(mk(0, 32'h0, 0, 0, 1, 1, 1, 32'h124));
        // Flush while full with a concurrent write of 0x20
        vecs.push_back(mk(1, 32'h200, 0, 0, 1, 1, 1, 32'h124));
        vecs.push_back(mk(1, 32'h20, 0, 1, 2, 0, 1, 32'h124));
        vecs.push_back(mk(0, 32'h0, 1, 0, 0, 1, 0, 32'h0));
        // Flush discarding an accepted-looking write into a non-full queue
        vecs.push_back(mk(1, 32'h30, 0, 0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 32'h40, 0, 1, 1, 1, 1, 32'h30));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 0, 32'h0));
        // Empty queue: write + d_ready gives only the write, presented next cycle
        vecs.push_back(mk(1, 32'h50, 1, 0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 1, 32'h50));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 0, 32'h0));

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.fv, v.pc, v.dr, v.fl);
            #1;
            check($sformatf("v%0d count", i), 32'(qif.count), 32'(v.exp_count));
            check($sformatf("v%0d f_ready", i), 32'(qif.f_ready), 32'(v.exp_f_ready));
            check($sformatf("v%0d d_valid", i), 32'(qif.d_valid), 32'(v.exp_d_valid));
            check($sformatf("v%0d d_pc", i), qif.d_pc, v.exp_d_pc);
            if (!v.exp_d_valid) check($sformatf("v%0d d_ins", i), qif.d_ins, NOP);
            if (v.fl) begin
                sb.delete();
            end else begin
                if (v.exp_d_valid && v.dr) begin
                    if (sb.size() == 0) begin
                        check($sformatf("v%0d scoreboard underflow", i), 32'd1, 32'd0);
                    end else begin
                        exp_pc = sb.pop_front();
                        check($sformatf("v%0d sb pc", i), qif.d_pc, exp_pc);
                        check($sformatf("v%0d sb ins", i), qif.d_ins, ins_of(exp_pc));
                        check($sformatf("v%0d sb pc4", i), qif.d_pc_plus_4, exp_pc + 32'd4);
                    end
                end
                if (v.fv && v.exp_f_ready) sb.push_back(v.pc);
            end
            @(negedge clk);
        end
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-operation with count=1
        drive(1, 32'h60, 0, 0);
        @(negedge clk);
        drive(0, 32'h0, 0, 0);
        #1;
        check("pre-areset count", 32'(qif.count), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("areset count", 32'(qif.count), 32'd0);
        check("areset d_valid", 32'(qif.d_valid), 32'd0);
        check("areset f_ready", 32'(qif.f_ready), 32'd1);
        check_empty_outputs("areset");
        @(negedge clk);
        rst = 1'b1;

`ifdef IFQ_BUBBLE_CNT_EN
        check("bubble after reset", bubble_cnt, 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 32'h0, 1, 0);
            @(negedge clk);
        end
        check("bubble 5", bubble_cnt, 32'd5);
        drive(0, 32'h0, 0, 1);
        @(negedge clk);
        drive(0, 32'h0, 0, 0);
        #1;
        check("bubble after flush", bubble_cnt, 32'd5);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
